// File: rtl/hd_serial_frame_rx_pkg.sv
// Shared definitions for the serial Hamming(7,4) frame receiver and the
// downstream decode/combine stage.
package hd_serial_frame_rx_pkg;

  localparam int WORD_W     = 7;
  localparam int FRAME_BITS = 2 * WORD_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PEND    = 2'd2
  } state_t;

  // Parity-check rows: bit i of the syndrome is the XOR of the word bits
  // selected by SYN_MASK[i].
  localparam logic [WORD_W-1:0] SYN_MASK0 = 7'b1001110;
  localparam logic [WORD_W-1:0] SYN_MASK1 = 7'b0101101;
  localparam logic [WORD_W-1:0] SYN_MASK2 = 7'b0011011;

  function automatic logic [2:0] syndrome(input logic [WORD_W-1:0] w);
    syndrome = {^(w & SYN_MASK2), ^(w & SYN_MASK1), ^(w & SYN_MASK0)};
  endfunction

endpackage

// File: rtl/hd_serial_frame_rx_syndrome_chk.sv
// Combinational Hamming(7,4) syndrome for one received word.
module hd_syndrome_chk
  import hd_serial_frame_rx_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [2:0]        o_syn,
  output logic              o_err
);

  // Syndrome bits and the nonzero flag.
  always_comb begin
    o_syn = syndrome(i_word);
    o_err = |o_syn;
  end

endmodule

// File: rtl/hd_serial_frame_rx.sv
// Bit-serial receiver: collects 14-bit frames (word1 then word2, MSB first),
// flags nonzero syndromes and hands frames downstream through a registered
// valid/ready output. The shift register doubles as a second frame buffer
// while the output register is occupied.
module hd_serial_frame_rx
  import hd_serial_frame_rx_pkg::*;
#(
  parameter int GAP_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] code_word1,
  output logic [WORD_W-1:0] code_word2,
  output logic              err1,
  output logic              err2,
  output logic              abort
);

  localparam int              GW       = (GAP_LIMIT > 0) ? $clog2(GAP_LIMIT + 1) : 1;
  localparam logic [GW-1:0]   GAP_LAST = GW'((GAP_LIMIT > 0) ? GAP_LIMIT - 1 : 0);
  localparam logic [3:0]      CNT_LAST = 4'(FRAME_BITS - 1);

  state_t                  r_state, w_state_nxt;
  logic [3:0]              r_cnt, w_cnt_nxt;
  logic [GW-1:0]           r_gap, w_gap_nxt;
  logic [FRAME_BITS-1:0]   r_shift, w_shift_nxt, w_frame;
  logic                    w_accept, w_drain, w_load, w_abort_nxt;
  logic                    r_abort;
  logic                    r_out_valid, r_err1, r_err2;
  logic [WORD_W-1:0]       r_cw1, r_cw2;
  logic [2:0]              w_syn1, w_syn2;
  logic                    w_err1, w_err2;
  logic                    w_unused;

  assign in_ready   = (r_state != PEND);
  assign w_accept   = in_valid && (r_state != PEND);
  assign w_drain    = r_out_valid && out_ready;

  assign out_valid  = r_out_valid;
  assign code_word1 = r_cw1;
  assign code_word2 = r_cw2;
  assign err1       = r_err1;
  assign err2       = r_err2;
  assign abort      = r_abort;

  // Frame candidate: in PEND the buffered frame, otherwise the shift
  // register with the incoming bit appended (the 14th bit loads directly).
  always_comb begin
    w_frame = (r_state == PEND) ? r_shift : {r_shift[FRAME_BITS-2:0], in_bit};
  end

  hd_syndrome_chk u_syn1 (
    .i_word (w_frame[FRAME_BITS-1:WORD_W]),
    .o_syn  (w_syn1),
    .o_err  (w_err1)
  );

  hd_syndrome_chk u_syn2 (
    .i_word (w_frame[WORD_W-1:0]),
    .o_syn  (w_syn2),
    .o_err  (w_err2)
  );

  // Only the nonzero flags are registered here; the raw syndromes belong to
  // the decode stage.
  assign w_unused = ^{w_syn1, w_syn2};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, collection counters and output-load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gap_nxt   = r_gap;
    w_shift_nxt = r_shift;
    w_load      = 1'b0;
    w_abort_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        w_gap_nxt = '0;
        if (w_accept) begin
          w_shift_nxt = w_frame;
          w_cnt_nxt   = 4'd1;
          w_state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (w_accept) begin
          w_shift_nxt = w_frame;
          w_gap_nxt   = '0;
          if (r_cnt == CNT_LAST) begin
            w_cnt_nxt = 4'd0;
            // Load straight through when the output slot is free or frees now.
            if (!r_out_valid || out_ready) begin
              w_load      = 1'b1;
              w_state_nxt = IDLE;
            end else begin
              w_state_nxt = PEND;
            end
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (GAP_LIMIT > 0) begin
          if (r_gap == GAP_LAST) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 4'd0;
            w_gap_nxt   = '0;
            w_abort_nxt = 1'b1;
          end else begin
            w_gap_nxt = r_gap + 1'b1;
          end
        end
      end
      PEND: begin
        if (w_drain) begin
          w_load      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Collection datapath and abort pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 4'd0;
      r_gap   <= '0;
      r_shift <= '0;
      r_abort <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nxt;
      r_gap   <= w_gap_nxt;
      r_shift <= w_shift_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  // Output register: load wins over drain so back-to-back frames keep
  // out_valid high with no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_cw1       <= '0;
      r_cw2       <= '0;
      r_err1      <= 1'b0;
      r_err2      <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_cw1       <= w_frame[FRAME_BITS-1:WORD_W];
      r_cw2       <= w_frame[WORD_W-1:0];
      r_err1      <= w_err1;
      r_err2      <= w_err2;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hd_serial_frame_rx.sv
// Directed bench for hd_serial_frame_rx with a frame scoreboard.
module tb_hd_serial_frame_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_bit = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [6:0] code_word1, code_word2;
  logic       err1, err2, abort;

  int n_tests = 0;
  int n_fail  = 0;
  int n_abort = 0;

  typedef struct {
    logic [6:0] c1;
    logic [6:0] c2;
    logic       e1;
    logic       e2;
  } frm_t;
  frm_t q[$];

  always #5 clk = ~clk;

  hd_serial_frame_rx #(.GAP_LIMIT(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_bit     (in_bit),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .code_word1 (code_word1),
    .code_word2 (code_word2),
    .err1       (err1),
    .err2       (err2),
    .abort      (abort)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic err_of(input logic [6:0] w);
    logic s0, s1, s2;
    s0 = w[6] ^ w[3] ^ w[2] ^ w[1];
    s1 = w[5] ^ w[3] ^ w[2] ^ w[0];
    s2 = w[4] ^ w[3] ^ w[1] ^ w[0];
    return s0 | s1 | s2;
  endfunction

  function automatic frm_t mk(input logic [6:0] c1, input logic [6:0] c2);
    frm_t f;
    f.c1 = c1; f.c2 = c2; f.e1 = err_of(c1); f.e2 = err_of(c2);
    return f;
  endfunction

  // Scoreboard: every handshake on the output pops one expected frame.
  always @(negedge clk) begin
    if (rst_n && abort) n_abort++;
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("sb_unexpected_frame", {code_word1, code_word2, err1, err2}, 16'hFFFF);
      end else begin
        frm_t e;
        e = q.pop_front();
        check("sb_cw1",  16'(code_word1), 16'(e.c1));
        check("sb_cw2",  16'(code_word2), 16'(e.c2));
        check("sb_err1", 16'(err1), 16'(e.e1));
        check("sb_err2", 16'(err2), 16'(e.e2));
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b);
    int k;
    in_valid = 1'b1;
    in_bit   = b;
    k = 0;
    while (!in_ready && k < 200) begin tick(); k++; end
    if (!in_ready) begin
      n_tests++; n_fail++;
      $error("FAIL send_bit_timeout: in_ready got 0 expected 1");
    end
    tick();
  endtask

  task automatic send_frame(input logic [6:0] c1, input logic [6:0] c2, input bit push);
    logic [13:0] f;
    f = {c1, c2};
    if (push) q.push_back(mk(c1, c2));
    for (int i = 13; i >= 0; i--) send_bit(f[i]);
    in_valid = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ov"},  16'(out_valid), 16'h0);
    check({tag, "_cw1"}, 16'(code_word1), 16'h0);
    check({tag, "_cw2"}, 16'(code_word2), 16'h0);
    check({tag, "_err"}, 16'({err1, err2}), 16'h0);
    check({tag, "_abt"}, 16'(abort), 16'h0);
  endtask

  initial begin
    int k;
    int ab0;
    logic [13:0] fb;

    // Reset state
    #12;
    check_zero("rst");
    check("rst_in_ready", 16'(in_ready), 16'h1);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Basic frame, no backpressure, one-cycle latency
    out_ready = 1'b1;
    send_frame(7'h1B, 7'h00, 1'b1);
    check("t1_ov_rise", 16'(out_valid), 16'h1);
    check("t1_cw1", 16'(code_word1), 16'h1B);
    check("t1_cw2", 16'(code_word2), 16'h00);
    check("t1_err", 16'({err1, err2}), 16'h0);
    tick();
    check("t1_ov_fall", 16'(out_valid), 16'h0);

    // Single-bit error in word1
    send_frame(7'h5B, 7'h1B, 1'b1);
    check("t2_err1", 16'(err1), 16'h1);
    check("t2_err2", 16'(err2), 16'h0);
    tick();

    // Backpressure: A held, B buffered, further bits refused
    out_ready = 1'b0;
    send_frame(7'h2C, 7'h55, 1'b1);
    send_frame(7'h71, 7'h0E, 1'b1);
    check("t3_pend_ready", 16'(in_ready), 16'h0);
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_ready", 16'(in_ready), 16'h0);
      check("t3_hold_cw1", 16'(code_word1), 16'h2C);
      check("t3_hold_ov", 16'(out_valid), 16'h1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_b_ov", 16'(out_valid), 16'h1);
    check("t3_b_cw1", 16'(code_word1), 16'h71);
    check("t3_b_cw2", 16'(code_word2), 16'h0E);
    check("t3_ready_back", 16'(in_ready), 16'h1);
    tick();
    out_ready = 1'b1;
    tick();
    check("t3_drained", 16'(out_valid), 16'h0);

    // Gap timeout after 5 bits
    fb = {7'h66, 7'h19};
    for (int i = 13; i >= 9; i--) send_bit(fb[i]);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_no_abort_yet", 16'(abort), 16'h0);
    end
    tick();
    check("t4_abort", 16'(abort), 16'h1);
    tick();
    check("t4_abort_pulse", 16'(abort), 16'h0);
    check("t4_no_ov", 16'(out_valid), 16'h0);
    send_frame(7'h66, 7'h19, 1'b1);
    tick();

    // Gaps of 3 cycles never time out
    ab0 = n_abort;
    fb = {7'h3A, 7'h47};
    for (int i = 13; i >= 5; i--) send_bit(fb[i]);
    q.push_back(mk(7'h3A, 7'h47));
    for (int i = 4; i >= 0; i--) begin
      in_valid = 1'b0;
      repeat (3) tick();
      send_bit(fb[i]);
    end
    in_valid = 1'b0;
    check("t5_ov", 16'(out_valid), 16'h1);
    tick();
    check("t5_no_abort", 16'(n_abort - ab0), 16'h0);

    // Async reset mid-frame
    for (int i = 0; i < 6; i++) send_bit(1'b1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("t6a");
    check("t6a_ready", 16'(in_ready), 16'h1);
    tick(); rst_n = 1'b1;
    tick();

    // Async reset while out_valid is held
    out_ready = 1'b0;
    send_frame(7'h12, 7'h34, 1'b0);
    check("t6b_ov_before", 16'(out_valid), 16'h1);
    #2 rst_n = 1'b0;
    #1 check_zero("t6b");
    tick(); rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    check("t6b_quiet", 16'(out_valid), 16'h0);
    send_frame(7'h69, 7'h33, 1'b1);
    check("t6b_fresh_cw1", 16'(code_word1), 16'h69);

    k = 0;
    while (q.size() != 0 && k < 50) begin tick(); k++; end
    check("sb_empty", 16'(q.size()), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
